// File: rtl/disp_page_sched_pkg.sv
// Shared encodings for the display page scheduler: page states, page-indicator
// codes driven on point_2, and the default all-blank digit pattern.
package disp_sched_pkg;

  typedef enum logic [1:0] {
    S_FREQ  = 2'd0,
    S_RANGE = 2'd1,
    S_MSG   = 2'd2
  } page_e;

  localparam logic [2:0] IND_FREQ  = 3'd0;
  localparam logic [2:0] IND_RANGE = 3'd1;
  localparam logic [2:0] IND_MSG   = 3'd2;

  localparam logic [31:0] BLANK_DEFAULT = 32'hFFFF_FFFF;

  function automatic logic [2:0] page_ind(page_e p);
    case (p)
      S_RANGE: page_ind = IND_RANGE;
      S_MSG:   page_ind = IND_MSG;
      default: page_ind = IND_FREQ;
    endcase
  endfunction

endpackage

// File: rtl/disp_page_sched_if.sv
// Source/display bundle of the page scheduler. master = requesters and display
// driver side, slave = the scheduler itself.
interface disp_page_sched_if;
  // Handshake: *_valid and msg_req are single-cycle strobes that are always
  // accepted (no ready); msg_ack pulses for one cycle after msg_req is sampled.
  logic [31:0] freq_data;
  logic [2:0]  freq_point;
  logic        freq_valid;
  logic [31:0] range_data;
  logic [2:0]  range_point;
  logic        range_valid;
  logic [31:0] msg_data;
  logic        msg_req;
  logic        msg_ack;
  logic        hold;
  logic [31:0] Disp_Data;
  logic [2:0]  point_1;
  logic [2:0]  point_2;
  logic [1:0]  page;

  modport master (
    output freq_data, freq_point, freq_valid,
    output range_data, range_point, range_valid,
    output msg_data, msg_req, hold,
    input  msg_ack, Disp_Data, point_1, point_2, page
  );

  modport slave (
    input  freq_data, freq_point, freq_valid,
    input  range_data, range_point, range_valid,
    input  msg_data, msg_req, hold,
    output msg_ack, Disp_Data, point_1, point_2, page
  );
endinterface

// File: rtl/disp_page_sched_ms_tick_gen.sv
// Free-running millisecond prescaler: tick is high for one Clk cycle out of
// every CLK_HZ/1000. Only Reset_n restarts it.
module ms_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic Clk,
  input  logic Reset_n,
  output logic tick
);
  localparam int DIV = CLK_HZ / 1000;
  localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/disp_page_sched.sv
// Time-slices the frequency and range pages onto the shared display path and
// pre-empts them with a blinking, timed status message.
module disp_page_sched
  import disp_sched_pkg::*;
#(
  parameter int          CLK_HZ     = 50_000_000,
  parameter int          PAGE_MS    = 2000,
  parameter int          MSG_MS     = 3000,
  parameter int          BLINK_MS   = 250,
  parameter logic [31:0] BLANK_CODE = BLANK_DEFAULT
) (
  input logic             Clk,
  input logic             Reset_n,
  disp_page_sched_if.slave bus
);
  localparam logic [15:0] PAGE_LAST  = 16'(PAGE_MS - 1);
  localparam logic [15:0] MSG_LAST   = 16'(MSG_MS - 1);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_MS - 1);

  page_e       state;
  page_e       ret_page;
  logic [15:0] page_cnt;
  logic [15:0] msg_cnt;
  logic [15:0] blink_cnt;
  logic        blink_phase;
  logic        tick;

  logic [31:0] freq_snap;
  logic [31:0] range_snap;
  logic [31:0] msg_snap;
  logic [2:0]  freq_pt;
  logic [2:0]  range_pt;

  logic [31:0] data_nxt;
  logic [2:0]  pt1_nxt;
  logic [2:0]  pt2_nxt;

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .tick    (tick)
  );

  // Measurement snapshots follow their strobes in every page, message included.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      freq_snap  <= '0;
      freq_pt    <= '0;
      range_snap <= '0;
      range_pt   <= '0;
    end else begin
      if (bus.freq_valid) begin
        freq_snap <= bus.freq_data;
        freq_pt   <= bus.freq_point;
      end
      if (bus.range_valid) begin
        range_snap <= bus.range_data;
        range_pt   <= bus.range_point;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state       <= S_FREQ;
      ret_page    <= S_FREQ;
      page_cnt    <= '0;
      msg_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      msg_snap    <= '0;
      bus.msg_ack <= 1'b0;
    end else begin
      bus.msg_ack <= bus.msg_req;
      if (bus.msg_req) begin
        // A request beats any same-cycle timeout or expiry; re-requests keep ret_page.
        msg_snap    <= bus.msg_data;
        msg_cnt     <= '0;
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
        if (state != S_MSG) ret_page <= state;
        state <= S_MSG;
      end else begin
        case (state)
          S_FREQ, S_RANGE: begin
            if (tick && !bus.hold) begin
              if (page_cnt == PAGE_LAST) begin
                state    <= (state == S_FREQ) ? S_RANGE : S_FREQ;
                page_cnt <= '0;
              end else begin
                page_cnt <= page_cnt + 16'd1;
              end
            end
          end
          S_MSG: begin
            if (tick) begin
              if (msg_cnt == MSG_LAST) begin
                state    <= ret_page;
                page_cnt <= '0;
              end else begin
                msg_cnt <= msg_cnt + 16'd1;
              end
              if (blink_cnt == BLINK_LAST) begin
                blink_phase <= ~blink_phase;
                blink_cnt   <= '0;
              end else begin
                blink_cnt <= blink_cnt + 16'd1;
              end
            end
          end
          default: state <= S_FREQ;
        endcase
      end
    end
  end

  always_comb begin
    data_nxt = freq_snap;
    pt1_nxt  = freq_pt;
    pt2_nxt  = page_ind(state);
    case (state)
      S_RANGE: begin
        data_nxt = range_snap;
        pt1_nxt  = range_pt;
      end
      S_MSG: begin
        data_nxt = blink_phase ? BLANK_CODE : msg_snap;
        pt1_nxt  = 3'd0;
      end
      default: ;
    endcase
  end

  // Output stage registers whole snapshots so the HC595 chain never sees a torn word.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      bus.Disp_Data <= '0;
      bus.point_1   <= '0;
      bus.point_2   <= '0;
    end else begin
      bus.Disp_Data <= data_nxt;
      bus.point_1   <= pt1_nxt;
      bus.point_2   <= pt2_nxt;
    end
  end

  assign bus.page = state;

endmodule

// File: tb/tb_disp_page_sched.sv
// Directed bench for disp_page_sched: rotation, hold, message blink/expiry,
// collisions and reset during a message. Tick is every 4th edge after reset.
module tb_disp_page_sched;

  localparam logic [31:0] BLANK = 32'hFFFF_FFFF;
  localparam logic [31:0] FREQ0 = 32'h0012_3456;
  localparam logic [31:0] RNG0  = 32'h0000_0A10;
  localparam logic [31:0] FREQ1 = 32'h0009_8765;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  int   ne;
  logic [31:0] exp_q[$];

  disp_page_sched_if bus ();

  disp_page_sched #(
    .CLK_HZ   (4000),
    .PAGE_MS  (3),
    .MSG_MS   (4),
    .BLINK_MS (1)
  ) dut (
    .Clk     (clk),
    .Reset_n (reset_n),
    .bus     (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic run_to(input int idx);
    while (ne <= idx) begin
      @(posedge clk);
      #1;
      ne++;
    end
  endtask

  // Scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_pop(input string tag);
    logic [31:0] expv;
    expv = 'x;
    if (exp_q.size() != 0) expv = exp_q.pop_front();
    chk(tag, bus.Disp_Data, expv);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ne       = 0;
    reset_n  = 1'b0;
    bus.freq_data   = '0;
    bus.freq_point  = '0;
    bus.freq_valid  = 1'b0;
    bus.range_data  = '0;
    bus.range_point = '0;
    bus.range_valid = 1'b0;
    bus.msg_data    = '0;
    bus.msg_req     = 1'b0;
    bus.hold        = 1'b0;

    // 1. Reset state and first snapshot latency
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", bus.Disp_Data, 32'h0);
    chk("rst_pt1", {29'd0, bus.point_1}, 32'd0);
    chk("rst_pt2", {29'd0, bus.point_2}, 32'd0);
    chk("rst_page", {30'd0, bus.page}, 32'd0);
    chk("rst_ack", {31'd0, bus.msg_ack}, 32'd0);
    reset_n = 1'b1;
    ne = 0;
    bus.freq_valid = 1'b1;
    bus.freq_data  = FREQ0;
    bus.freq_point = 3'd2;
    exp_q.push_back(32'h0);
    exp_q.push_back(FREQ0);
    run_to(0);
    bus.freq_valid  = 1'b0;
    bus.range_valid = 1'b1;
    bus.range_data  = RNG0;
    bus.range_point = 3'd5;
    chk_pop("freq_lat_e0");
    run_to(1);
    bus.range_valid = 1'b0;
    chk_pop("freq_lat_e1");
    chk("freq_pt1", {29'd0, bus.point_1}, 32'd2);

    // 2. Rotation every 12 cycles
    run_to(10);
    chk("rot_pre", {30'd0, bus.page}, 32'd0);
    run_to(11);
    chk("rot_range", {30'd0, bus.page}, 32'd1);
    chk("rot_pt2_lag", {29'd0, bus.point_2}, 32'd0);
    exp_q.push_back(RNG0);
    run_to(12);
    chk_pop("rot_range_data");
    chk("rot_range_pt1", {29'd0, bus.point_1}, 32'd5);
    chk("rot_range_pt2", {29'd0, bus.point_2}, 32'd1);
    run_to(22);
    chk("rot_range_stay", {30'd0, bus.page}, 32'd1);
    run_to(23);
    chk("rot_freq", {30'd0, bus.page}, 32'd0);
    exp_q.push_back(FREQ0);
    run_to(24);
    chk_pop("rot_freq_data");
    chk("rot_freq_pt1", {29'd0, bus.point_1}, 32'd2);
    chk("rot_freq_pt2", {29'd0, bus.point_2}, 32'd0);

    // 3. Hold freezes rotation in RANGE
    run_to(35);
    chk("hold_range", {30'd0, bus.page}, 32'd1);
    run_to(40);
    bus.hold = 1'b1;
    run_to(47);
    chk("hold_no_switch", {30'd0, bus.page}, 32'd1);
    run_to(80);
    chk("hold_end", {30'd0, bus.page}, 32'd1);
    bus.hold = 1'b0;
    run_to(86);
    chk("hold_remain", {30'd0, bus.page}, 32'd1);
    run_to(87);
    chk("hold_switch", {30'd0, bus.page}, 32'd0);

    // 4. Message from RANGE: ack, blink, return
    run_to(99);
    chk("msg_pre_range", {30'd0, bus.page}, 32'd1);
    run_to(100);
    bus.msg_req  = 1'b1;
    bus.msg_data = 32'hE0E0_0001;
    exp_q.push_back(32'hE0E0_0001);
    exp_q.push_back(BLANK);
    exp_q.push_back(32'hE0E0_0001);
    exp_q.push_back(BLANK);
    exp_q.push_back(RNG0);
    run_to(101);
    bus.msg_req = 1'b0;
    chk("msg_page", {30'd0, bus.page}, 32'd2);
    chk("msg_ack_hi", {31'd0, bus.msg_ack}, 32'd1);
    run_to(102);
    chk("msg_ack_lo", {31'd0, bus.msg_ack}, 32'd0);
    chk_pop("msg_show0");
    chk("msg_pt1", {29'd0, bus.point_1}, 32'd0);
    chk("msg_pt2", {29'd0, bus.point_2}, 32'd2);
    run_to(104);
    chk_pop("msg_blank0");
    run_to(108);
    chk_pop("msg_show1");
    run_to(112);
    chk_pop("msg_blank1");
    run_to(114);
    chk("msg_still", {30'd0, bus.page}, 32'd2);
    run_to(115);
    chk("msg_return", {30'd0, bus.page}, 32'd1);
    run_to(116);
    chk_pop("msg_return_data");
    chk("msg_return_pt2", {29'd0, bus.point_2}, 32'd1);

    // 5a. Request on the page-timeout edge returns to the old page
    run_to(126);
    chk("col_pre", {30'd0, bus.page}, 32'd1);
    bus.msg_req  = 1'b1;
    bus.msg_data = 32'h1111_2222;
    run_to(127);
    bus.msg_req = 1'b0;
    chk("col_page", {30'd0, bus.page}, 32'd2);
    chk("col_ack", {31'd0, bus.msg_ack}, 32'd1);
    run_to(142);
    chk("col_hold", {30'd0, bus.page}, 32'd2);
    run_to(143);
    chk("col_ret_old", {30'd0, bus.page}, 32'd1);

    // 5b/5c. Re-request mid-message; freq update while in MSG
    run_to(155);
    chk("re_pre_freq", {30'd0, bus.page}, 32'd0);
    run_to(156);
    bus.msg_req  = 1'b1;
    bus.msg_data = 32'hAAAA_0001;
    exp_q.push_back(32'hAAAA_0001);
    run_to(157);
    bus.msg_req = 1'b0;
    run_to(158);
    chk_pop("re_first_data");
    run_to(164);
    bus.msg_req  = 1'b1;
    bus.msg_data = 32'hBBBB_0002;
    exp_q.push_back(32'hBBBB_0002);
    run_to(165);
    bus.msg_req = 1'b0;
    chk("re_ack_hi", {31'd0, bus.msg_ack}, 32'd1);
    run_to(166);
    chk("re_ack_lo", {31'd0, bus.msg_ack}, 32'd0);
    chk_pop("re_new_data");
    run_to(168);
    exp_q.push_back(BLANK);
    chk_pop("re_blank");
    bus.freq_valid = 1'b1;
    bus.freq_data  = FREQ1;
    bus.freq_point = 3'd1;
    run_to(169);
    bus.freq_valid = 1'b0;
    run_to(171);
    chk("re_restart", {30'd0, bus.page}, 32'd2);
    exp_q.push_back(32'hBBBB_0002);
    run_to(172);
    chk_pop("re_msg_not_freq");
    run_to(178);
    chk("re_hold_end", {30'd0, bus.page}, 32'd2);
    run_to(179);
    chk("re_ret_freq", {30'd0, bus.page}, 32'd0);
    exp_q.push_back(FREQ1);
    run_to(180);
    chk_pop("re_freq_new");
    chk("re_freq_pt1", {29'd0, bus.point_1}, 32'd1);

    // 6. Reset during a message, coinciding with a fresh request
    bus.msg_req  = 1'b1;
    bus.msg_data = 32'hCCCC_0003;
    run_to(181);
    bus.msg_req = 1'b0;
    chk("rm_page", {30'd0, bus.page}, 32'd2);
    chk("rm_ack", {31'd0, bus.msg_ack}, 32'd1);
    run_to(182);
    reset_n      = 1'b0;
    bus.msg_req  = 1'b1;
    bus.msg_data = 32'hDDDD_0004;
    run_to(183);
    reset_n     = 1'b1;
    bus.msg_req = 1'b0;
    ne = 0;
    chk("rm_rst_page", {30'd0, bus.page}, 32'd0);
    chk("rm_rst_ack", {31'd0, bus.msg_ack}, 32'd0);
    chk("rm_rst_data", bus.Disp_Data, 32'h0);
    run_to(0);
    chk("rm_e0_ack", {31'd0, bus.msg_ack}, 32'd0);
    chk("rm_e0_data", bus.Disp_Data, 32'h0);
    chk("rm_e0_page", {30'd0, bus.page}, 32'd0);
    run_to(1);
    chk("rm_e1_ack", {31'd0, bus.msg_ack}, 32'd0);
    run_to(10);
    chk("rm_rot_pre", {30'd0, bus.page}, 32'd0);
    run_to(11);
    chk("rm_rot", {30'd0, bus.page}, 32'd1);
    run_to(12);
    chk("rm_range_data", bus.Disp_Data, 32'h0);
    chk("rm_range_pt2", {29'd0, bus.point_2}, 32'd1);

    chk("queue_empty", exp_q.size(), 32'd0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
